// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
// Holds the data/address bus widths, the reset PC and NOP defaults, the
// in-flight bound, the FSM state encoding and the FIFO entry layout used by
// instr_fetch and its fetch_fifo.
package instr_fetch_pkg;

  localparam int XLEN = 32;
  localparam int ALEN = 32;

  localparam logic [ALEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  // Outstanding requests plus buffered instructions never exceed this.
  localparam int MAX_INFLIGHT = 2;
  localparam int FIFO_DEPTH   = 2;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [ALEN-1:0] addr;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low two bits are forced to 0.
  function automatic logic [ALEN-1:0] align_word(input logic [ALEN-1:0] a);
    return {a[ALEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order FIFO holding fetched instructions with their addresses.
// Ports:
//   clk, rst_n   - clock and asynchronous active-low reset
//   flush        - empties the FIFO; takes precedence over push/pop
//   push         - write push_data at the tail
//   push_data    - 64-bit entry (address + instruction)
//   pop          - drop the head entry
//   pop_data     - current head entry (valid when !empty)
//   full, empty  - occupancy flags
//   count        - number of entries held (0..2)
module fetch_fifo
  import instr_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t pop_data,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  fetch_entry_t entry_q [FIFO_DEPTH];
  fetch_entry_t entry_d [FIFO_DEPTH];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign full     = (count_q == 2'd2);
  assign empty    = (count_q == 2'd0);
  assign count    = count_q;
  assign pop_data = entry_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when the head leaves in the
  // same cycle, so the slot it vacates can take the new entry.
  always_comb begin
    entry_d  = entry_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        entry_d[wr_ptr_q] = push_data;
        wr_ptr_d          = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q  <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      entry_q  <= entry_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues sequential word fetches to instruction
// memory, buffers the in-order responses and hands them to the decoder.
// A redirect (jmp_en) reloads the pc, flushes the buffer and discards the
// responses of requests that were already in flight.
// Ports:
//   clk, rst_n                    - clock, asynchronous active-low reset
//   imem_req_valid/ready/addr     - fetch request handshake and address
//   imem_rsp_valid/data           - in-order fetch responses
//   jmp_en, jmp_addr              - redirect request from execute
//   instr, addr_instr             - instruction and its address to decode
//   instr_valid, instr_ready      - decode handshake
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [ALEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [ALEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            jmp_en,
  input  logic [ALEN-1:0] jmp_addr,
  output logic [XLEN-1:0] instr,
  output logic [ALEN-1:0] addr_instr,
  output logic            instr_valid,
  input  logic            instr_ready
);

  fetch_state_e    state_q, state_d;
  logic [ALEN-1:0] pc_q, pc_d;
  logic [1:0]      out_cnt_q, out_cnt_d;
  logic [1:0]      drop_cnt_q, drop_cnt_d;

  logic            jmp_act;
  logic [2:0]      inflight;
  logic            req_fire;
  logic            rsp_take;
  logic            rsp_keep;
  logic            instr_fire;
  logic [ALEN-1:0] rsp_addr;

  fetch_entry_t    fifo_push_data;
  fetch_entry_t    fifo_head;
  logic            fifo_push;
  logic            fifo_full;
  logic            fifo_empty;
  logic [1:0]      fifo_count;

  // Redirects are only honoured once fetching has started.
  assign jmp_act  = jmp_en && (state_q != BOOT);
  assign inflight = {1'b0, out_cnt_q} + {1'b0, fifo_count};

  // No request is raised alongside jmp_en so the old stream cannot leak a
  // fetch into the cycle of the redirect.
  assign imem_req_valid = (state_q == RUN) && !jmp_en &&
                          (inflight < 3'(MAX_INFLIGHT));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding are stray and ignored.
  assign rsp_take = imem_rsp_valid && (out_cnt_q != 2'd0);
  assign rsp_keep = rsp_take && (state_q == RUN) && !jmp_act;

  // In RUN the outstanding requests are the words just below pc, so the
  // oldest one (the one now answering) sits out_cnt words behind it.
  assign rsp_addr = pc_q - {28'd0, out_cnt_q, 2'b00};

  assign fifo_push_data = '{addr: rsp_addr, instr: imem_rsp_data};
  assign fifo_push      = rsp_keep && !fifo_full;

  assign instr_valid = !fifo_empty;
  assign instr_fire  = instr_valid && instr_ready;
  assign instr       = fifo_empty ? NOP_INSTR : fifo_head.instr;
  assign addr_instr  = fifo_empty ? '0 : fifo_head.addr;

  fetch_fifo u_fetch_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (jmp_act),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (instr_fire),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next-state logic. A redirect overrides the sequential pc update and
  // loads drop_cnt with everything still owed by memory after this cycle.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    out_cnt_d  = out_cnt_q + {1'b0, req_fire} - {1'b0, rsp_take};

    if (req_fire) begin
      pc_d = pc_q + 32'd4;
    end

    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN, DRAIN: begin
        if (jmp_act) begin
          pc_d       = align_word(jmp_addr);
          drop_cnt_d = out_cnt_d;
          state_d    = (out_cnt_d != 2'd0) ? DRAIN : RUN;
        end else if (state_q == DRAIN) begin
          if (rsp_take) begin
            drop_cnt_d = drop_cnt_q - 2'd1;
          end
          if (drop_cnt_d == 2'd0) begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= align_word(RESET_PC);
      out_cnt_q  <= 2'd0;
      drop_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch. A queue-based memory model answers
// requests one cycle after acceptance unless held; a second instance with
// RESET_PC = 0xFFFF_FFF8 exercises pc wrap-around. Memory word for address
// a is a ^ 32'h5A00_0000.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        jmp_en;
  logic [31:0] jmp_addr;
  logic [31:0] instr, addr_instr;
  logic        instr_valid, instr_ready;
  logic        mem_hold;

  logic        req2_valid;
  logic [31:0] req2_addr;
  logic        rsp2_valid;
  logic [31:0] rsp2_data;
  logic [31:0] instr2, addr_instr2;
  logic        instr_valid2;

  logic [31:0] pend_q[$];
  logic [31:0] req_log[$];
  logic [31:0] req2_log[$];
  logic [31:0] del_addr[$];
  logic [31:0] del_data[$];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  instr_fetch u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (req_valid),
    .imem_req_ready (req_ready),
    .imem_req_addr  (req_addr),
    .imem_rsp_valid (rsp_valid),
    .imem_rsp_data  (rsp_data),
    .jmp_en         (jmp_en),
    .jmp_addr       (jmp_addr),
    .instr          (instr),
    .addr_instr     (addr_instr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (req2_valid),
    .imem_req_ready (1'b1),
    .imem_req_addr  (req2_addr),
    .imem_rsp_valid (rsp2_valid),
    .imem_rsp_data  (rsp2_data),
    .jmp_en         (1'b0),
    .jmp_addr       (32'h0),
    .instr          (instr2),
    .addr_instr     (addr_instr2),
    .instr_valid    (instr_valid2),
    .instr_ready    (1'b1)
  );

  // Memory model: accepted requests queue up; the head is returned the
  // cycle after acceptance unless mem_hold stalls it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q.delete();
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if (req_valid && req_ready) pend_q.push_back(req_addr);
      if (!mem_hold && pend_q.size() > 0) begin
        rsp_valid <= 1'b1;
        rsp_data  <= pend_q.pop_front() ^ 32'h5A00_0000;
      end else begin
        rsp_valid <= 1'b0;
        rsp_data  <= '0;
      end
    end
  end

  // Fixed one-cycle responder for the wrap-around instance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp2_valid <= 1'b0;
      rsp2_data  <= '0;
    end else begin
      rsp2_valid <= req2_valid;
      rsp2_data  <= req2_addr;
    end
  end

  // Transfer logs, recorded on the edge where each handshake completes.
  always @(posedge clk) begin
    if (rst_n) begin
      if (req_valid && req_ready) req_log.push_back(req_addr);
      if (req2_valid) req2_log.push_back(req2_addr);
      if (instr_valid && instr_ready) begin
        del_addr.push_back(addr_instr);
        del_data.push_back(instr);
      end
    end
  end

  function automatic logic [31:0] logAt(input logic [31:0] q[$], input int i);
    return (q.size() > i) ? q[i] : 32'hDEAD_DEAD;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic jen, input logic [31:0] jaddr,
                               input logic hold, input logic irdy);
    @(negedge clk);
    jmp_en      = jen;
    jmp_addr    = jaddr;
    mem_hold    = hold;
    instr_ready = irdy;
  endtask

  task automatic clearLogs();
    req_log.delete();
    req2_log.delete();
    del_addr.delete();
    del_data.delete();
  endtask

  task automatic doReset(input logic hold, input logic irdy);
    @(negedge clk);
    rst_n       = 1'b0;
    jmp_en      = 1'b0;
    jmp_addr    = '0;
    req_ready   = 1'b1;
    instr_ready = irdy;
    mem_hold    = hold;
    clearLogs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    jmp_en = 1'b0; jmp_addr = '0; req_ready = 1'b1;
    instr_ready = 1'b1; mem_hold = 1'b0;

    // Reset values while rst_n is held low
    #12;
    checkOutput("rst_req_valid",   {31'd0, req_valid},   32'd0);
    checkOutput("rst_req_addr",    req_addr,             32'h0);
    checkOutput("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rst_instr",       instr,                32'h0000_0013);
    checkOutput("rst_addr_instr",  addr_instr,           32'h0);
    checkOutput("rst2_req_addr",   req2_addr,            32'hFFFF_FFF8);
    checkOutput("rst2_instr",      instr2,               32'h0000_0013);
    checkOutput("rst2_addr_instr", addr_instr2,          32'h0);
    checkOutput("rst2_valid",      {31'd0, instr_valid2}, 32'd0);

    // Basic streaming with a one-cycle memory
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("boot_no_req", {31'd0, req_valid}, 32'd0);
    @(posedge clk); #1;
    checkOutput("e0_req_valid", {31'd0, req_valid}, 32'd1);
    checkOutput("e0_req_addr",  req_addr,           32'h0);
    @(posedge clk); #1;
    checkOutput("e1_instr_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("e1_req_addr",    req_addr,             32'h4);
    @(posedge clk); #1;
    checkOutput("e2_instr_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("e2_addr_instr",  addr_instr,           32'h0);
    checkOutput("e2_instr",       instr,                32'h5A00_0000);
    checkOutput("e2_bound",       {31'd0, req_valid},   32'd0);
    repeat (8) @(negedge clk);
    checkOutput("seq_req0", logAt(req_log, 0), 32'h0);
    checkOutput("seq_req1", logAt(req_log, 1), 32'h4);
    checkOutput("seq_req2", logAt(req_log, 2), 32'h8);
    checkOutput("seq_del0", logAt(del_addr, 0), 32'h0);
    checkOutput("seq_del1", logAt(del_addr, 1), 32'h4);
    checkOutput("seq_del2", logAt(del_addr, 2), 32'h8);
    checkOutput("seq_dat1", logAt(del_data, 1), 32'h5A00_0004);
    checkOutput("wrap_req0", logAt(req2_log, 0), 32'hFFFF_FFF8);
    checkOutput("wrap_req1", logAt(req2_log, 1), 32'hFFFF_FFFC);
    checkOutput("wrap_req2", logAt(req2_log, 2), 32'h0000_0000);

    // Decoder stalled: only two fetches, head held stable
    doReset(1'b0, 1'b0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("stall_hold_addr", addr_instr, 32'h0);
    end
    checkOutput("stall_hold_instr", instr, 32'h5A00_0000);
    checkOutput("stall_req_count", 32'(req_log.size()), 32'd2);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    repeat (12) @(negedge clk);
    checkOutput("resume_del0", logAt(del_addr, 0), 32'h0);
    checkOutput("resume_del1", logAt(del_addr, 1), 32'h4);
    checkOutput("resume_del2", logAt(del_addr, 2), 32'h8);
    checkOutput("resume_del3", logAt(del_addr, 3), 32'hC);

    // Redirect with two requests outstanding
    doReset(1'b1, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("jmp_pre_reqs", 32'(req_log.size()), 32'd2);
    clearLogs();
    applyStimulus(1'b1, 32'h0000_0103, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("jmp_req0", logAt(req_log, 0),  32'h0000_0100);
    checkOutput("jmp_del0", logAt(del_addr, 0), 32'h0000_0100);
    checkOutput("jmp_dat0", logAt(del_data, 0), 32'h5A00_0100);

    // Jump with nothing outstanding, then a second jump during DRAIN
    doReset(1'b1, 1'b1);
    @(negedge clk);
    checkOutput("nojmp_req_valid", {31'd0, req_valid}, 32'd1);
    jmp_en = 1'b1; jmp_addr = 32'h0000_0200;
    #1 checkOutput("jmp_blocks_req", {31'd0, req_valid}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("j0_req0", logAt(req_log, 0), 32'h0000_0200);
    checkOutput("j0_req1", logAt(req_log, 1), 32'h0000_0204);
    clearLogs();
    applyStimulus(1'b1, 32'h0000_0400, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h0000_0300, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("j2_req0", logAt(req_log, 0),  32'h0000_0300);
    checkOutput("j2_req1", logAt(req_log, 1),  32'h0000_0304);
    checkOutput("j2_del0", logAt(del_addr, 0), 32'h0000_0300);
    checkOutput("j2_dat0", logAt(del_data, 0), 32'h5A00_0300);

    // Asynchronous reset while an instruction is buffered
    doReset(1'b0, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk); #2;
    checkOutput("mid_pre_ivalid", {31'd0, instr_valid}, 32'd1);
    checkOutput("mid_pre_rvalid", {31'd0, req_valid},   32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ivalid", {31'd0, instr_valid}, 32'd0);
    checkOutput("mid_rst_rvalid", {31'd0, req_valid},   32'd0);
    checkOutput("mid_rst_instr",  instr,                32'h0000_0013);
    checkOutput("mid_rst_addr",   req_addr,             32'h0);
    clearLogs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("mid_refetch_req", logAt(req_log, 0),  32'h0);
    checkOutput("mid_refetch_del", logAt(del_addr, 0), 32'h0);
    checkOutput("mid_refetch_dat", logAt(del_data, 0), 32'h5A00_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
